// File: rtl/video_pkg.sv
// Shared video-side definitions: command opcodes, sequencer states, and the
// default frame geometry used by the sprite frame sequencer.
package video_pkg;

    localparam int FRAME_SIZE_DEF     = 70400;  // 400x176 ROM words per frame
    localparam int NUM_FRAMES_MAX_DEF = 16;

    typedef enum logic [1:0] {
        OP_PLAY      = 2'd0,
        OP_PAUSE     = 2'd1,
        OP_STEP      = 2'd2,
        OP_SET_FRAME = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_PAUSED    = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_STEP_PEND = 2'd2
    } seq_state_e;

    // Frame count actually used for wrapping: clamp to the supported maximum
    // and never below one, so a zero count behaves as a single still frame.
    function automatic logic [7:0] eff_count(input logic [7:0] num, input logic [7:0] max_n);
        logic [7:0] c;
        c = (num > max_n) ? max_n : num;
        if (c == 8'd0) c = 8'd1;
        return c;
    endfunction

endpackage

// File: rtl/sprite_frame_sequencer_if.sv
// Command channel of the sprite frame sequencer.
// Handshake: a command transfers on a cycle where cmd_valid and cmd_ready are
// both high (and the video clock enable is high); the master holds op/arg
// stable while cmd_valid is high, and cmd_ready may drop while a STEP is pending.
interface sprite_frame_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/vblank_edge_det.sv
// Clock-enable qualified rising-edge detector for the vertical blank signal.
module vblank_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic cen_i,
    input  logic vblank_i,
    output logic rise_o
);
    logic prev_q, prev_d;

    // History only moves on enabled cycles so the edge is seen at video rate.
    always_comb begin
        prev_d = cen_i ? vblank_i : prev_q;
        rise_o = cen_i & vblank_i & ~prev_q;
    end

    // Previous-vblank register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) prev_q <= 1'b0;
        else         prev_q <= prev_d;
    end
endmodule

// File: rtl/sprite_frame_sequencer.sv
// Sprite animation frame sequencer: steps a frame index on vertical blank
// under PLAY/PAUSE/STEP/SET_FRAME control and publishes the ROM base address.
module sprite_frame_sequencer
    import video_pkg::*;
#(
    parameter int FRAME_SIZE     = FRAME_SIZE_DEF,
    parameter int NUM_FRAMES_MAX = NUM_FRAMES_MAX_DEF,
    parameter int ADDR_W         = 22
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cen_i,
    input  logic              vblank_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [7:0]        cmd_arg_i,
    input  logic [7:0]        delay_i,
    input  logic [7:0]        num_frames_i,
    output logic [7:0]        frame_idx_o,
    output logic [ADDR_W-1:0] frame_base_o,
    output logic              frame_tick_o,
    output logic [1:0]        state_o
);
    sprite_frame_sequencer_if cmd_bus ();

    seq_state_e        state_q, state_d;
    logic [7:0]        idx_q, idx_d;
    logic [7:0]        dcnt_q, dcnt_d;
    logic [7:0]        target_q, target_d;
    logic              pend_q, pend_d;
    logic              tick_q, tick_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              vb_rise;
    logic              cmd_fire;
    logic [7:0]        eff;
    logic [7:0]        next_idx;
    cmd_op_e           op;

    assign cmd_bus.cmd_valid = cmd_valid_i;
    assign cmd_bus.cmd_op    = cmd_op_i;
    assign cmd_bus.cmd_arg   = cmd_arg_i;
    assign cmd_ready_o       = cmd_bus.cmd_ready;

    vblank_edge_det u_vblank_edge_det (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .cen_i    (cen_i),
        .vblank_i (vblank_i),
        .rise_o   (vb_rise)
    );

    // Handshake and index helpers; a pending SET_FRAME keeps the port open
    // even while a STEP waits for its vblank.
    always_comb begin
        cmd_bus.cmd_ready = (state_q != ST_STEP_PEND) || pend_q;
        cmd_fire          = cen_i & cmd_bus.cmd_valid & cmd_bus.cmd_ready;
        op                = cmd_op_e'(cmd_bus.cmd_op);
        eff               = eff_count(num_frames_i, 8'(NUM_FRAMES_MAX));
        next_idx          = (idx_q >= eff - 8'd1) ? 8'd0 : idx_q + 8'd1;
    end

    // Next-state: the vblank is resolved first on the pre-command state, then
    // an accepted command modifies the result for the following vblank.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dcnt_d   = dcnt_q;
        target_d = target_q;
        pend_d   = pend_q;
        tick_d   = 1'b0;
        if (cen_i) begin
            if (vb_rise) begin
                if (pend_q) begin
                    idx_d  = target_q;
                    pend_d = 1'b0;
                    dcnt_d = 8'd0;
                    tick_d = 1'b1;
                    if (state_q == ST_STEP_PEND) state_d = ST_PAUSED;
                end else begin
                    case (state_q)
                        ST_PLAYING: begin
                            if (dcnt_q >= delay_i) begin
                                dcnt_d = 8'd0;
                                idx_d  = next_idx;
                                tick_d = 1'b1;
                            end else begin
                                dcnt_d = dcnt_q + 8'd1;
                            end
                        end
                        ST_STEP_PEND: begin
                            idx_d   = next_idx;
                            tick_d  = 1'b1;
                            state_d = ST_PAUSED;
                        end
                        default: ;
                    endcase
                end
            end
            if (cmd_fire) begin
                case (op)
                    OP_PLAY:  if (state_d == ST_PAUSED) state_d = ST_PLAYING;
                    OP_PAUSE: if (state_d == ST_PLAYING) begin
                        state_d = ST_PAUSED;
                        dcnt_d  = 8'd0;
                    end
                    OP_STEP:  if (state_d == ST_PAUSED) state_d = ST_STEP_PEND;
                    OP_SET_FRAME: begin
                        pend_d   = 1'b1;
                        target_d = (cmd_bus.cmd_arg >= eff) ? 8'd0 : cmd_bus.cmd_arg;
                    end
                    default: ;
                endcase
            end
        end
        // Constant multiply on the next index keeps the base in step with idx.
        base_d = ADDR_W'(idx_d) * ADDR_W'(FRAME_SIZE);
    end

    // Sequencer state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_PAUSED;
            idx_q    <= 8'd0;
            dcnt_q   <= 8'd0;
            target_q <= 8'd0;
            pend_q   <= 1'b0;
            tick_q   <= 1'b0;
            base_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dcnt_q   <= dcnt_d;
            target_q <= target_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
            base_q   <= base_d;
        end
    end

    assign frame_idx_o  = idx_q;
    assign frame_base_o = base_q;
    assign frame_tick_o = tick_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// Directed bench for the sprite frame sequencer with a tick scoreboard.
module tb_sprite_frame_sequencer;
    localparam int FS = 70400;
    localparam int W  = 30;

    logic        clk;
    logic        rst_n;
    logic        cen;
    logic        vblank;
    logic [7:0]  delay;
    logic [7:0]  num_frames;
    logic [7:0]  frame_idx;
    logic [21:0] frame_base;
    logic        frame_tick;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    sprite_frame_sequencer_if bus ();

    sprite_frame_sequencer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cen_i        (cen),
        .vblank_i     (vblank),
        .cmd_valid_i  (bus.cmd_valid),
        .cmd_ready_o  (bus.cmd_ready),
        .cmd_op_i     (bus.cmd_op),
        .cmd_arg_i    (bus.cmd_arg),
        .delay_i      (delay),
        .num_frames_i (num_frames),
        .frame_idx_o  (frame_idx),
        .frame_base_o (frame_base),
        .frame_tick_o (frame_tick),
        .state_o      (state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] exp_item(input int idx);
        logic [7:0]  i;
        logic [21:0] b;
        i = 8'(idx);
        b = 22'(idx * FS);
        return {i, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vblank_pulse();
        vblank = 1'b1;
        step_clk(1);
        vblank = 1'b0;
        step_clk(2);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg);
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            step_clk(1);
            n++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL cmd_ready_timeout actual=0 expected=1");
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        step_clk(1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_state", 32'(state), 0);
        check("rst_idx", 32'(frame_idx), 0);
        check("rst_base", 32'(frame_base), 0);
        check("rst_tick", 32'(frame_tick), 0);
        check("rst_ready", 32'(bus.cmd_ready), 1);
        step_clk(2);
        rst_n = 1'b1;
        step_clk(1);
    endtask

    // Monitor: every tick pops one expected {idx, base} pair.
    always @(negedge clk) begin
        if (rst_n && frame_tick) begin
            logic [W-1:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_tick actual_idx=%0d expected=no_tick", frame_idx);
            end else begin
                e = exp_q.pop_front();
                if ({frame_idx, frame_base} !== e) begin
                    failures++;
                    $display("FAIL tick_frame actual_idx=%0d actual_base=%0d expected_idx=%0d expected_base=%0d",
                             frame_idx, frame_base, e[W-1:22], e[21:0]);
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        cen           = 1'b1;
        vblank        = 1'b0;
        delay         = 8'd0;
        num_frames    = 8'd10;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_arg   = 8'd0;
        step_clk(2);

        // STEP from PAUSED: port closes until the vblank, one advance.
        do_reset();
        send_cmd(2'd2, 8'd0);
        check("step_state_pend", 32'(state), 2);
        check("step_ready_low", 32'(bus.cmd_ready), 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd2;
        step_clk(3);
        check("step_again_ready_low", 32'(bus.cmd_ready), 0);
        check("step_again_state", 32'(state), 2);
        bus.cmd_valid = 1'b0;
        exp_q.push_back(exp_item(1));
        vblank_pulse();
        check("step_state_paused", 32'(state), 0);
        check("step_idx", 32'(frame_idx), 1);
        check("step_ready_high", 32'(bus.cmd_ready), 1);
        vblank_pulse();
        check("step_no_more_advance", 32'(frame_idx), 1);

        // PLAY with delay 5 over ten frames: advance every sixth vblank.
        do_reset();
        delay      = 8'd5;
        num_frames = 8'd10;
        send_cmd(2'd0, 8'd0);
        check("play_state", 32'(state), 1);
        for (int v = 1; v <= 70; v++) begin
            if (v % 6 == 0) exp_q.push_back(exp_item((v / 6) % 10));
            vblank_pulse();
            if (v == 54) check("base_at_idx9", 32'(frame_base), 633600);
        end
        check("play_final_idx", 32'(frame_idx), 1);
        send_cmd(2'd1, 8'd0);
        check("pause_state", 32'(state), 0);

        // SET_FRAME mid-frame while PLAYING.
        do_reset();
        delay      = 8'd5;
        num_frames = 8'd10;
        send_cmd(2'd0, 8'd0);
        vblank_pulse();
        vblank_pulse();
        send_cmd(2'd3, 8'd7);
        exp_q.push_back(exp_item(7));
        vblank_pulse();
        check("setf_idx7", 32'(frame_idx), 7);
        check("setf_base7", 32'(frame_base), 492800);
        check("setf_state", 32'(state), 1);
        for (int v = 0; v < 5; v++) vblank_pulse();
        check("setf_dcnt_cleared", 32'(frame_idx), 7);
        exp_q.push_back(exp_item(8));
        vblank_pulse();
        send_cmd(2'd3, 8'd12);
        exp_q.push_back(exp_item(0));
        vblank_pulse();
        check("setf_out_of_range", 32'(frame_idx), 0);
        send_cmd(2'd3, 8'd3);
        send_cmd(2'd3, 8'd5);
        exp_q.push_back(exp_item(5));
        vblank_pulse();
        check("setf_overwrite", 32'(frame_idx), 5);

        // PLAY coinciding with a vblank rise while PAUSED.
        do_reset();
        delay      = 8'd0;
        num_frames = 8'd10;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd0;
        vblank        = 1'b1;
        step_clk(1);
        bus.cmd_valid = 1'b0;
        vblank        = 1'b0;
        step_clk(2);
        check("same_cycle_state", 32'(state), 1);
        check("same_cycle_idx", 32'(frame_idx), 0);
        exp_q.push_back(exp_item(1));
        vblank_pulse();
        exp_q.push_back(exp_item(2));
        vblank_pulse();

        // Clock enable low across a vblank edge and a command.
        cen    = 1'b0;
        vblank = 1'b1;
        step_clk(2);
        vblank = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd1;
        step_clk(2);
        bus.cmd_valid = 1'b0;
        step_clk(1);
        check("cen_low_state", 32'(state), 1);
        check("cen_low_idx", 32'(frame_idx), 2);
        cen = 1'b1;
        step_clk(1);
        exp_q.push_back(exp_item(3));
        vblank_pulse();
        check("cen_resume_idx", 32'(frame_idx), 3);

        // Reset while a STEP is pending.
        send_cmd(2'd1, 8'd0);
        send_cmd(2'd2, 8'd0);
        check("pre_reset_pend", 32'(state), 2);
        do_reset();

        // Zero frame count: idx pinned at 0, tick on every advance.
        delay      = 8'd0;
        num_frames = 8'd0;
        send_cmd(2'd0, 8'd0);
        exp_q.push_back(exp_item(0));
        vblank_pulse();
        exp_q.push_back(exp_item(0));
        vblank_pulse();
        check("zero_count_idx", 32'(frame_idx), 0);

        step_clk(5);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
